// File: rtl/sentinel_pkg.sv
// sentinel_pkg: shared constants and state encoding for the Sentinel auth arbiter
package sentinel_pkg;
  localparam logic [7:0] SENTINEL_KEY = 8'hB6;
  localparam int STRIKE_W = 2;
  localparam int ESC_W = 2;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_GRANT   = 3'd1;
  localparam state_t ST_CHECK   = 3'd2;
  localparam state_t ST_LOCKOUT = 3'd3;
  localparam state_t ST_FUSED   = 3'd4;
endpackage

// File: rtl/lockout_timer.sv
// lockout_timer: loadable down-counter that freezes when disabled and flags zero
module lockout_timer #(
  parameter int unsigned TIMER_W = 28
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);
  logic [TIMER_W-1:0] r_cnt;
  // load wins over counting; the count parks at zero
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign zero = (r_cnt == '0);
endmodule

// File: rtl/sentinel_auth_arbiter.sv
// sentinel_auth_arbiter: round-robin key comparator sharing with strike lockout and tamper fuse
module sentinel_auth_arbiter
  import sentinel_pkg::*;
#(
  parameter logic [7:0]  KEY          = SENTINEL_KEY,
  parameter int unsigned MAX_STRIKES  = 3,
  parameter int unsigned LOCKOUT_BASE = 16,
  parameter int unsigned TIMER_W      = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                req_a,
  input  logic [7:0]          key_a,
  input  logic                req_b,
  input  logic [7:0]          key_b,
  input  logic                tamper,
  output logic                gnt_a,
  output logic                gnt_b,
  output logic                done,
  output logic                pass,
  output logic                lockout,
  output logic [STRIKE_W-1:0] strikes,
  output logic [ESC_W-1:0]    esc,
  output logic                fused
);
  if (MAX_STRIKES < 1 || MAX_STRIKES > 3) begin : g_bad_strikes
    $error("MAX_STRIKES must be in 1..3");
  end
  if (LOCKOUT_BASE == 0 || (64'(LOCKOUT_BASE) << 3) >= (64'd1 << TIMER_W)) begin : g_bad_timer
    $error("LOCKOUT_BASE must be >= 1 and LOCKOUT_BASE<<3 must fit in TIMER_W bits");
  end
  state_t              r_state;
  state_t              w_next;
  logic                r_owner;
  logic                r_ptr;
  logic                r_match;
  logic [STRIKE_W-1:0] r_strikes;
  logic [ESC_W-1:0]    r_esc;
  logic [STRIKE_W-1:0] w_strike_inc;
  logic                w_pick_b;
  logic                w_commit;
  logic                w_lock_go;
  logic                w_tmr_zero;
  assign w_pick_b     = req_b && (!req_a || r_ptr);
  assign w_strike_inc = r_strikes + 1'b1;
  assign w_commit     = (r_state == ST_CHECK) && ena && !tamper;
  assign w_lock_go    = w_commit && !r_match && (w_strike_inc == STRIKE_W'(MAX_STRIKES));
  // next-state selection; tamper overrides every state
  always_comb begin
    w_next = ST_IDLE;
    if (tamper) w_next = ST_FUSED;
    else case (r_state)
      ST_IDLE:    w_next = (ena && (req_a || req_b)) ? ST_GRANT : ST_IDLE;
      ST_GRANT:   w_next = ena ? ST_CHECK : ST_IDLE;
      ST_CHECK:   w_next = w_lock_go ? ST_LOCKOUT : ST_IDLE;
      ST_LOCKOUT: w_next = w_tmr_zero ? ST_IDLE : ST_LOCKOUT;
      ST_FUSED:   w_next = ST_FUSED;
      default:    w_next = ST_IDLE;
    endcase
  end
  // state, arbitration pointer, key capture and strike/escalation bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_ptr     <= 1'b0;
      r_match   <= 1'b0;
      r_strikes <= '0;
      r_esc     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_next == ST_GRANT) begin
        r_owner <= w_pick_b;
        r_ptr   <= !w_pick_b;
      end
      if (r_state == ST_GRANT) r_match <= ((r_owner ? key_b : key_a) == KEY);
      if (w_commit) begin
        if (r_match) begin
          r_strikes <= '0;
          r_esc     <= '0;
        end else if (w_lock_go) begin
          r_strikes <= '0;
          r_esc     <= (r_esc == '1) ? r_esc : r_esc + 1'b1;
        end else r_strikes <= w_strike_inc;
      end
    end
  end
  lockout_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_lock_go),
    .load_val (TIMER_W'(LOCKOUT_BASE) << r_esc),
    .en       ((r_state == ST_LOCKOUT) && ena),
    .zero     (w_tmr_zero)
  );
  assign gnt_a   = (r_state == ST_GRANT || r_state == ST_CHECK) && !r_owner;
  assign gnt_b   = (r_state == ST_GRANT || r_state == ST_CHECK) && r_owner;
  assign done    = (r_state == ST_CHECK);
  assign pass    = (r_state == ST_CHECK) && r_match;
  assign lockout = (r_state == ST_LOCKOUT);
  assign fused   = (r_state == ST_FUSED);
  assign strikes = r_strikes;
  assign esc     = r_esc;
endmodule

// File: tb/tb_sentinel_auth_arbiter.sv
// tb_sentinel_auth_arbiter: directed and randomized transactions checked against a transaction-level model
module tb_sentinel_auth_arbiter;
  localparam logic [7:0] KEY = 8'hB6;
  localparam int MAXS = 3;
  localparam int BASE = 16;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic [7:0] key_a = 8'h00;
  logic [7:0] key_b = 8'h00;
  logic       tamper = 1'b0;
  logic       gnt_a, gnt_b, done, pass, lockout, fused;
  logic [1:0] strikes, esc;
  int n_checks = 0;
  int n_pass = 0;
  bit m_ptr_b = 1'b0;
  int m_strikes = 0;
  int m_esc = 0;

  sentinel_auth_arbiter #(.KEY(KEY), .MAX_STRIKES(MAXS), .LOCKOUT_BASE(BASE), .TIMER_W(28)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req_a(req_a), .key_a(key_a), .req_b(req_b), .key_b(key_b),
    .tamper(tamper), .gnt_a(gnt_a), .gnt_b(gnt_b), .done(done), .pass(pass), .lockout(lockout),
    .strikes(strikes), .esc(esc), .fused(fused)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic lock_wait(input int len, input int drop);
    int cnt = 0;
    bit leaked = 1'b0;
    while (lockout === 1'b1 && cnt < 2000) begin
      cnt++;
      req_a = 1'($urandom_range(0, 1));
      req_b = 1'($urandom_range(0, 1));
      key_a = KEY;
      key_b = KEY;
      ena = !(drop > 0 && cnt >= 5 && cnt < 5 + drop);
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || done !== 1'b0) leaked = 1'b1;
      tick();
    end
    req_a = 1'b0;
    req_b = 1'b0;
    ena = 1'b1;
    chk("lock_len", cnt, len + 1 + drop);
    chk("lock_quiet", 32'(leaked), 0);
    chk("lock_strikes", 32'(strikes), 0);
  endtask

  task automatic txn(input bit ra, input bit rb, input logic [7:0] ka, input logic [7:0] kb,
                     input bit keep, input int drop);
    bit own_b;
    bit pass_e;
    int len;
    own_b = rb && (!ra || m_ptr_b);
    m_ptr_b = !own_b;
    pass_e = ((own_b ? kb : ka) == KEY);
    len = 0;
    if (pass_e) begin
      m_strikes = 0;
      m_esc = 0;
    end else if (m_strikes + 1 == MAXS) begin
      m_strikes = 0;
      len = BASE * (1 << m_esc);
      m_esc = (m_esc == 3) ? 3 : m_esc + 1;
    end else m_strikes++;
    req_a = ra;
    req_b = rb;
    key_a = ka;
    key_b = kb;
    tick();
    chk("grant_a", 32'(gnt_a), 32'(!own_b));
    chk("grant_b", 32'(gnt_b), 32'(own_b));
    chk("grant_nodone", 32'(done), 0);
    if (!keep) begin
      req_a = 1'b0;
      req_b = 1'b0;
    end
    tick();
    chk("check_done", 32'(done), 1);
    chk("check_pass", 32'(pass), 32'(pass_e));
    chk("check_owner", 32'(gnt_b), 32'(own_b));
    tick();
    chk("after_strikes", 32'(strikes), m_strikes);
    chk("after_esc", 32'(esc), m_esc);
    chk("after_lockout", 32'(lockout), 32'(len > 0));
    chk("after_nodone", 32'(done), 0);
    if (len > 0) lock_wait(len, drop);
  endtask

  initial begin
    bit leaked;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_gnt", {30'd0, gnt_a, gnt_b}, 0);
    chk("rst_done", {30'd0, done, pass}, 0);
    chk("rst_lockout", 32'(lockout), 0);
    chk("rst_fused", 32'(fused), 0);
    chk("rst_counters", {28'd0, strikes, esc}, 0);
    // single correct key on A
    txn(1, 0, KEY, 8'h00, 0, 0);
    // both requesting continuously with correct keys: strict alternation
    for (int i = 0; i < 4; i++) txn(1, 1, KEY, KEY, 1, 0);
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    // three wrong keys then first lockout
    for (int i = 0; i < 3; i++) txn(1, 0, 8'h00, 8'h00, 0, 0);
    // second lockout doubles, with ena dropped mid-lockout for 10 cycles
    for (int i = 0; i < 3; i++) txn(0, 1, 8'h00, 8'h00, 0, i == 2 ? 10 : 0);
    chk("esc_after_two", 32'(esc), 2);
    // a correct key clears escalation
    txn(0, 1, 8'h00, KEY, 0, 0);
    // ena dropped during GRANT aborts without a verdict
    txn(1, 0, 8'h11, 8'h00, 0, 0);
    req_a = 1'b1;
    req_b = 1'b1;
    key_a = 8'h00;
    key_b = 8'h00;
    tick();
    chk("abort_granted", 32'(gnt_a | gnt_b), 1);
    chk("abort_owner", 32'(gnt_b), 32'(m_ptr_b));
    m_ptr_b = !m_ptr_b;
    req_a = 1'b0;
    req_b = 1'b0;
    ena = 1'b0;
    tick();
    chk("abort_nodone", 32'(done), 0);
    chk("abort_nogrant", 32'(gnt_a | gnt_b), 0);
    ena = 1'b1;
    tick();
    chk("abort_strikes", 32'(strikes), m_strikes);
    // randomized transactions
    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(1, 3);
      txn(r[0], r[1],
          $urandom_range(0, 1) ? KEY : 8'($urandom_range(0, 255)),
          $urandom_range(0, 1) ? KEY : 8'($urandom_range(0, 255)), 0, 0);
    end
    // make sure strikes are nonzero before tamper
    if (m_strikes == 0) txn(1, 0, 8'h00, 8'h00, 0, 0);
    // tamper during CHECK with a wrong key
    req_a = 1'b1;
    key_a = 8'h5A;
    tick();
    req_a = 1'b0;
    tick();
    chk("tamper_done", 32'(done), 1);
    chk("tamper_pass", 32'(pass), 0);
    tamper = 1'b1;
    tick();
    tamper = 1'b0;
    chk("tamper_fused", 32'(fused), 1);
    chk("tamper_strikes", 32'(strikes), m_strikes);
    chk("tamper_esc", 32'(esc), m_esc);
    leaked = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    key_a = KEY;
    key_b = KEY;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || done !== 1'b0 || lockout !== 1'b0 || fused !== 1'b1) leaked = 1'b1;
    end
    chk("fused_quiet", 32'(leaked), 0);
    req_a = 1'b0;
    req_b = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr_b = 1'b0;
    m_strikes = 0;
    m_esc = 0;
    chk("rst2_fused", 32'(fused), 0);
    chk("rst2_counters", {28'd0, strikes, esc}, 0);
    txn(1, 1, KEY, KEY, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sentinel_auth_arbiter.md
# sentinel_auth_arbiter

Sequences access to the Sentinel key comparator and shares it between two key requesters: A is the DIP-switch port and B is the serial telemetry port. One requester at a time is granted, its key is captured and compared against the hardcoded key, and a one-cycle verdict is returned. The block also counts failed attempts, enforces an escalating lockout, and latches a permanent fused state on tamper. It sits between the key interfaces and the display/status logic of the Sentinel top level.

## Interface
Parameters:
- `KEY`, 8'hB6, authorization key.
- `MAX_STRIKES`, 3, consecutive failures that trigger a lockout (range 1..3).
- `LOCKOUT_BASE`, 16, first lockout length in cycles (≥1).
- `TIMER_W`, 28, lockout timer width. `LOCKOUT_BASE<<3` must fit; elaboration fails otherwise.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `ena`, in, 1: power-state enable.
- `req_a`, in, 1: requester A wants a comparison.
- `key_a`, in, 8: requester A key. Held stable while `gnt_a`=1.
- `req_b`, in, 1: requester B wants a comparison.
- `key_b`, in, 8: requester B key. Held stable while `gnt_b`=1.
- `tamper`, in, 1: tamper strobe from the loopback monitor.
- `gnt_a`, out, 1: A owns the comparator. Reset 0.
- `gnt_b`, out, 1: B owns the comparator. Reset 0.
- `done`, out, 1: one-cycle verdict strobe. Reset 0.
- `pass`, out, 1: key matched. Valid only when `done`=1, otherwise 0. Reset 0.
- `lockout`, out, 1: lockout active. Reset 0.
- `strikes`, out, 2: current consecutive failure count. Reset 0.
- `esc`, out, 2: lockout escalation level. Reset 0.
- `fused`, out, 1: permanently fused until `rst`. Reset 0.

## Operation
- States: IDLE, GRANT, CHECK, LOCKOUT, FUSED. Reset state is IDLE.
- All outputs decode from registered state only. There is no combinational path from any input to any output.

IDLE
- With `ena`=1 and any request pending, go to GRANT with owner chosen round-robin.
- The pointer favours A after reset. After any grant it points to the other requester.
- A lone request is granted regardless of the pointer.
- With `ena`=0, requests are ignored.

GRANT
- `gnt_owner`=1.
- Capture `match_q <= (key_owner == KEY)`.
- Next state is CHECK.

CHECK
- `gnt_owner`=1, `done`=1, `pass`=`match_q`.
- On pass: clear `strikes` and `esc`, then go to IDLE.
- On fail: increment `strikes`.
  - If it reaches `MAX_STRIKES`: clear `strikes`, load the timer with `LOCKOUT_BASE << esc`, saturate-increment `esc` (max 3), and go to LOCKOUT.
  - Otherwise go to IDLE.

LOCKOUT
- `lockout`=1. No grants; requests are ignored.
- The timer decrements when `ena`=1 and freezes when `ena`=0. Toggling `ena` does not escape the lockout.
- The cycle after the timer reads 0, go to IDLE.

FUSED
- Entered the cycle after `tamper`=1, from any state. Tamper has top priority.
- `fused`=1. No grants; `done`, `pass`, and `lockout` are 0.
- Left only by `rst`.

Boundary rules
- `ena`=0 in GRANT: abort to IDLE. No `done`, no strike change, round-robin pointer still advances.
- `ena`=0 in CHECK: `done`/`pass` still assert that cycle, since they decode from state. Strike and lockout updates are suppressed and the next state is IDLE.
- `tamper` in CHECK: `done`/`pass` still assert that cycle. Strike, `esc`, and timer updates are discarded, and the next state is FUSED.
- A requester still asserting `req` after `done` is re-arbitrated normally. If the other requester is also pending, the other one wins.
- `rst` mid-operation: every register returns to its reset value on the next edge, including the fuse.

## Timing
- Request latency, with `req_a` first seen at edge N in IDLE:
  - `gnt_a`=1 during N+1 (GRANT); `key_a` is sampled at the end of N+1.
  - `done` is asserted during N+2 (CHECK).
  - IDLE or LOCKOUT from N+3.
- Throughput: one comparison every 3 cycles.
- Lockout length: `LOCKOUT_BASE << esc_at_entry` cycles of `ena`=1, plus 1 exit cycle. With defaults this is 16, 32, 64, then 128 thereafter.
- The `strikes` and `esc` counters saturate; neither wraps.

## Structure
- `sentinel_pkg`: state enum, default key constant `SENTINEL_KEY` (8'hB6), width constants for `strikes` and `esc`.
- Sub-module `lockout_timer`: `TIMER_W` down-counter with load, enable/freeze, and zero flag.
- FSM, arbiter pointer, and counters live in the top module.

## Test plan
- Reset, then `req_a` with `key_a`=0xB6 → `gnt_a` high 2 cycles, `done`=1 and `pass`=1 two cycles after the request, `strikes`=0.
- `req_a` and `req_b` both high continuously with correct keys → grants alternate A, B, A, B. Each `done` is 3 cycles apart.
- Three wrong keys (0x00) → `strikes` 1, 2, then `lockout`=1 for 16 cycles with requests ignored. Repeat → 32 cycles, `esc`=2. A correct key afterwards clears `esc`.
- `ena` dropped for 10 cycles mid-lockout → lockout ends 10 cycles later than nominal. `ena` dropped in GRANT → no `done`, `strikes` unchanged.
- `tamper` pulse during CHECK with a wrong key → `done` seen, `strikes` unchanged, then `fused`=1 and no further grants until `rst`, which clears everything.
